// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch control path and its display packing.
// Digit indices follow cnt_bcd packing: centiseconds in the low nibbles, hours in the top.
package stopwatch_pkg;

  localparam int BCD_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = BCD_DIGITS * DIGIT_W;

  localparam int CENT_0 = 0;
  localparam int CENT_1 = 1;
  localparam int SEC_0  = 2;
  localparam int SEC_1  = 3;
  localparam int MIN_0  = 4;
  localparam int MIN_1  = 5;
  localparam int HR_0   = 6;
  localparam int HR_1   = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    RUN_LAP  = 3'd2,
    STOP     = 3'd3,
    STOP_LAP = 3'd4
  } state_t;

  function automatic logic [DIGIT_W-1:0] bcd_digit(input logic [BCD_W-1:0] bcd, input int idx);
    return bcd[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw button -> 2-FF sync -> level debouncer -> registered 1-cycle press pulse.
// Latency raw press to pulse: 2 + DEBOUNCE_MS + 1 cycles; no backpressure, release is silent.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20,
  parameter int CNT_W       = 8
) (
  input  logic clk_milisec,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync_0;
  logic             sync_1;
  logic [1:0]       sync_fill;
  logic             level;
  logic             level_q;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_milisec) begin
    if (rst) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      sync_fill <= 2'b00;
      level     <= 1'b0;
      level_q   <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_0    <= btn;
      sync_1    <= sync_0;
      sync_fill <= {sync_fill[0], 1'b1};

      // A button held through reset must be seen released before its next rise counts.
      if (sync_fill[1] && !sync_1) begin
        armed <= 1'b1;
      end

      if (sync_1 != level) begin
        if (cnt == LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end

      level_q <= level;
      press   <= level & ~level_q & armed;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/split buttons drive a 5-state FSM, lap freeze and display mux.
// Latency: state moves 1 cycle after a press pulse; disp_bcd is 0-cycle from cnt_bcd; no backpressure.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int CNT_W       = 8
) (
  input  logic             clk_milisec,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_split,
  input  logic [BCD_W-1:0] cnt_bcd,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [BCD_W-1:0] disp_bcd,
  output logic             disp_frozen,
  output logic [2:0]       state_o
);

  state_t           state;
  logic             start_p;
  logic             split_p;
  logic             rst_q;
  logic [BCD_W-1:0] lap_q;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_db_start (
    .clk_milisec (clk_milisec),
    .rst         (rst),
    .btn         (btn_start),
    .press       (start_p)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_db_split (
    .clk_milisec (clk_milisec),
    .rst         (rst),
    .btn         (btn_split),
    .press       (split_p)
  );

  // Start has priority: every branch tests start_p before split_p.
  always_ff @(posedge clk_milisec) begin
    if (rst) begin
      state   <= IDLE;
      lap_q   <= '0;
      cnt_clr <= 1'b1;
      rst_q   <= 1'b1;
    end else begin
      rst_q   <= 1'b0;
      cnt_clr <= rst_q;
      case (state)
        IDLE: begin
          if (start_p) state <= RUN;
        end
        RUN: begin
          if (start_p) begin
            state <= STOP;
          end else if (split_p) begin
            state <= RUN_LAP;
            lap_q <= cnt_bcd;
          end
        end
        RUN_LAP: begin
          if (start_p)      state <= STOP_LAP;
          else if (split_p) state <= RUN;
        end
        STOP: begin
          if (start_p) begin
            state <= RUN;
          end else if (split_p) begin
            state   <= IDLE;
            cnt_clr <= 1'b1;
          end
        end
        STOP_LAP: begin
          if (start_p)      state <= RUN_LAP;
          else if (split_p) state <= STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cnt_en      = (state == RUN) || (state == RUN_LAP);
  assign disp_frozen = (state == RUN_LAP) || (state == STOP_LAP);
  assign disp_bcd    = disp_frozen ? lap_q : cnt_bcd;
  assign state_o     = state;

endmodule
